// File: rtl/serial_adder_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial adder controller.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder step per clock, LSB first,
// with a registered carry and a start/busy/done handshake.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_ctrl_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] op_a_r;
  logic [WIDTH-1:0] op_b_r;
  logic [WIDTH-1:0] acc_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;

  logic             accept_s;
  logic             step_s;
  logic             last_s;
  logic             bit_s;
  logic             carry_s;
  logic [WIDTH:0]   shift_s;
  logic [WIDTH-1:0] acc_next_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; a request is taken in IDLE or DONE, ignored in RUN.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    step_s   = 1'b0;
    last_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          accept_s = 1'b1;
          state_s  = ST_RUN;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_RUN: begin
        step_s = 1'b1;
        if (cnt_r == CW'(WIDTH - 1)) begin
          last_s  = 1'b1;
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          accept_s = 1'b1;
          state_s  = ST_RUN;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Single full-adder cell and the MSB-side accumulator shift.
  always_comb begin
    bit_s      = op_a_r[0] ^ op_b_r[0] ^ carry_r;
    carry_s    = (op_a_r[0] & op_b_r[0]) | (op_a_r[0] & carry_r) | (op_b_r[0] & carry_r);
    shift_s    = {bit_s, acc_r};
    acc_next_s = shift_s[WIDTH:1];
  end

  // Operand capture, bit stepping, and result load on the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_r  <= '0;
      op_b_r  <= '0;
      acc_r   <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
    end else if (accept_s) begin
      op_a_r  <= bus.a;
      op_b_r  <= bus.b;
      acc_r   <= '0;
      carry_r <= bus.cin;
      cnt_r   <= '0;
    end else if (step_s) begin
      op_a_r  <= op_a_r >> 1;
      op_b_r  <= op_b_r >> 1;
      acc_r   <= acc_next_s;
      carry_r <= carry_s;
      cnt_r   <= cnt_r + CW'(1);
      if (last_s) begin
        sum_r  <= acc_next_s;
        cout_r <= carry_s;
      end
    end
  end

  assign bus.busy = (state_r == ST_RUN);
  assign bus.done = (state_r == ST_DONE);
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed vectors, corner sequences,
// random operands against a plain-arithmetic model, and exhaustive WIDTH=1.
module tb_serial_adder_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_adder_ctrl_if #(.WIDTH(1)) bus1 ();

  serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_adder_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       mid_start;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  vec_t       vecs[5];
  logic [7:0] prev_sum8;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one 8-bit operation; operands are scrambled during RUN to show they are not used.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic mid_start, output logic [7:0] s, output logic co,
                        output int busy_n, output int cyc, output int hold_bad);
    @(posedge clk); #1;
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.cin = ci;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    busy_n = 0; cyc = 0; hold_bad = 0;
    while (cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (bus8.done) break;
      if (bus8.busy) busy_n++;
      if (bus8.sum !== prev_sum8) hold_bad++;
      bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
      if (mid_start && cyc == 3) begin
        bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF;
      end else begin
        bus8.start = 1'b0;
      end
    end
    s  = bus8.sum;
    co = bus8.cout;
  endtask

  task automatic do_op1(input logic a, input logic b, input logic ci,
                        output logic s, output logic co, output int busy_n, output int cyc);
    @(posedge clk); #1;
    bus1.start = 1'b1; bus1.a = a; bus1.b = b; bus1.cin = ci;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    busy_n = 0; cyc = 0;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (bus1.done) break;
      if (bus1.busy) busy_n++;
    end
    s  = bus1.sum[0];
    co = bus1.cout;
  endtask

  initial begin
    logic [7:0] s;
    logic       co;
    logic       s1;
    logic       co1;
    logic [8:0] model;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic [1:0] fa_tt[8];
    int         busy_n;
    int         cyc;
    int         hold_bad;
    int         first_done;
    int         second_done;
    int         n_done;

    checks = 0;
    errors = 0;
    vecs[0] = '{a: 8'h00, b: 8'h00, cin: 1'b0, mid_start: 1'b0, exp_sum: 8'h00, exp_cout: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, mid_start: 1'b0, exp_sum: 8'h00, exp_cout: 1'b1};
    vecs[2] = '{a: 8'hA5, b: 8'h5A, cin: 1'b1, mid_start: 1'b0, exp_sum: 8'h00, exp_cout: 1'b1};
    vecs[3] = '{a: 8'hA5, b: 8'h5A, cin: 1'b0, mid_start: 1'b0, exp_sum: 8'hFF, exp_cout: 1'b0};
    vecs[4] = '{a: 8'h3C, b: 8'h0F, cin: 1'b0, mid_start: 1'b1, exp_sum: 8'h4B, exp_cout: 1'b0};
    fa_tt = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    rst_n = 1'b0;
    bus8.start = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00; bus8.cin = 1'b0;
    bus1.start = 1'b0; bus1.a = 1'b0;  bus1.b = 1'b0;  bus1.cin = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(bus8.busy), 32'd0);
    check("reset_done", 32'(bus8.done), 32'd0);
    check("reset_sum",  32'(bus8.sum),  32'd0);
    check("reset_cout", 32'(bus8.cout), 32'd0);
    rst_n = 1'b1;
    prev_sum8 = 8'h00;

    for (int i = 0; i < 5; i++) begin
      do_op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].mid_start, s, co, busy_n, cyc, hold_bad);
      check($sformatf("vec%0d_sum", i), 32'(s), 32'(vecs[i].exp_sum));
      check($sformatf("vec%0d_cout", i), 32'(co), 32'(vecs[i].exp_cout));
      check($sformatf("vec%0d_busy_cycles", i), 32'(busy_n), 32'd8);
      check($sformatf("vec%0d_done_latency", i), 32'(cyc), 32'd9);
      check($sformatf("vec%0d_sum_hold", i), 32'(hold_bad), 32'd0);
      prev_sum8 = vecs[i].exp_sum;
      @(negedge clk);
      check($sformatf("vec%0d_idle_after", i), 32'({bus8.busy, bus8.done}), 32'd0);
    end

    // Start held high through DONE: back-to-back operations every WIDTH+1 cycles.
    @(posedge clk); #1;
    bus8.start = 1'b1; bus8.a = 8'h3C; bus8.b = 8'h0F; bus8.cin = 1'b0;
    first_done = -1; second_done = -1; cyc = 0;
    repeat (25) begin
      @(negedge clk);
      cyc++;
      if (bus8.done) begin
        if (first_done < 0) first_done = cyc;
        else if (second_done < 0) second_done = cyc;
      end
    end
    bus8.start = 1'b0;
    check("b2b_spacing", 32'(second_done - first_done), 32'd9);
    check("b2b_sum", 32'(bus8.sum), 32'h4B);
    repeat (12) @(negedge clk);

    // Reset in the fourth RUN cycle aborts the operation with no done pulse.
    @(posedge clk); #1;
    bus8.start = 1'b1; bus8.a = 8'h7F; bus8.b = 8'h7F; bus8.cin = 1'b0;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_pre_busy", 32'(bus8.busy), 32'd1);
    check("rst_pre_sum", 32'(bus8.sum), 32'h4B);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_busy", 32'(bus8.busy), 32'd0);
    check("rst_async_done", 32'(bus8.done), 32'd0);
    check("rst_async_sum",  32'(bus8.sum),  32'd0);
    check("rst_async_cout", 32'(bus8.cout), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus8.done || bus8.busy) n_done++;
    end
    check("rst_no_done", 32'(n_done), 32'd0);
    prev_sum8 = 8'h00;
    do_op8(8'h7F, 8'h7F, 1'b0, 1'b0, s, co, busy_n, cyc, hold_bad);
    check("rst_fresh_sum", 32'(s), 32'hFE);
    check("rst_fresh_cout", 32'(co), 32'd0);
    check("rst_fresh_latency", 32'(cyc), 32'd9);
    prev_sum8 = 8'hFE;

    // Random operands against plain arithmetic.
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      model = {1'b0, ra} + {1'b0, rb} + 9'(rc);
      do_op8(ra, rb, rc, 1'($urandom), s, co, busy_n, cyc, hold_bad);
      check($sformatf("rand%0d_result", i), 32'({co, s}), 32'(model));
      check($sformatf("rand%0d_latency", i), 32'(cyc), 32'd9);
      check($sformatf("rand%0d_sum_hold", i), 32'(hold_bad), 32'd0);
      prev_sum8 = model[7:0];
    end

    // WIDTH=1: exhaustive full-adder truth table.
    for (int i = 0; i < 8; i++) begin
      do_op1(1'(i >> 2), 1'(i >> 1), 1'(i), s1, co1, busy_n, cyc);
      check($sformatf("w1_case%0d_result", i), 32'({co1, s1}), 32'(fa_tt[i]));
      check($sformatf("w1_case%0d_busy_cycles", i), 32'(busy_n), 32'd1);
      check($sformatf("w1_case%0d_done_latency", i), 32'(cyc), 32'd2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
